alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//  Parametrised decode-and-execute ALU for the RV32 core's EX stage: merges ALU-control decode
//  (alu_op/funct3/funct7/op) with a registered datapath. Adds SLTU, SRA and the M-extension
//  multiply group, executed by an iterative shift-add engine. Valid/ready on both sides.
// PARAMETERS
//  XLEN        32  operand/result width (power of two, >= 8); shift amount = low $clog2(XLEN) bits of operand_b
//  ENABLE_MUL  1   1: MUL/MULH/MULHSU/MULHU supported; 0: multiply group decoded as illegal
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     synchronous abort of in-flight op and pending result
//  in_valid   in   1     request valid
//  in_ready   out  1     request accepted when in_valid & in_ready
//  alu_op     in   2     00 ADD, 01 SUB, 10 funct-decoded, 11 illegal
//  funct3     in   3     instruction funct3
//  funct7_5   in   1     instruction bit 30
//  funct7_0   in   1     instruction bit 25 (M-extension select)
//  op_5       in   1     opcode bit 5 (1 = R-type)
//  operand_a  in   XLEN  rs1 value
//  operand_b  in   XLEN  rs2 value or immediate
//  out_valid  out  1     result valid; held until out_ready
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  ALU result
//  zero       out  1     result == 0
//  illegal    out  1     op not supported; result forced to 0
//  busy       out  1     multiply iteration in progress
// BEHAVIOUR
//  Reset: state IDLE; out_valid, result, zero(=0 here), illegal, busy all 0; multiplier regs 0.
//  Decode (alu_op==10): 000 ADD, or SUB if op_5&funct7_5; 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//   101 SRL, or SRA if funct7_5; 110 OR; 111 AND. If op_5&funct7_0: funct3 000 MUL, 001 MULH,
//   010 MULHSU, 011 MULHU, 1xx illegal (no divide). alu_op==11 illegal. funct7_5 ignored for I-type ADD.
//  in_ready = (state==IDLE) & (~out_valid | out_ready) & ~flush.
//  Single-cycle ops: accepted in cycle N -> result/zero/illegal registered, out_valid=1 in N+1.
//   Back-to-back accept permitted each cycle while out_ready=1 (throughput 1/cycle).
//  Arithmetic: ADD/SUB modulo 2^XLEN; SLT signed, SLTU unsigned, result 0/1 zero-extended;
//   SRA sign-fills; shift amount 0 returns operand_a unchanged.
//  FSM: IDLE -> MUL (on accepted multiply) -> IDLE. MUL: busy=1, in_ready=0 for exactly XLEN cycles;
//   engine uses operand magnitudes (signed per op: MULH a,b signed; MULHSU a signed only), one
//   partial-product bit per cycle into a 2*XLEN accumulator, negates on sign mismatch at end.
//   MUL returns low XLEN bits, MULH* high XLEN bits. out_valid rises at cycle N+XLEN+1.
//  Output hold: while out_valid & ~out_ready, result/zero/illegal stable, no new accept.
//  flush: next edge state=IDLE, out_valid=0, busy=0; flush with in_valid same cycle -> not accepted.
//  Reset mid-multiply: abort immediately to reset values; no result emitted.
//  ENABLE_MUL=0: multiply group -> illegal=1, result=0, latency 1, multiplier logic absent.
// TESTING
//  1 alu_op=10,f3=000,op_5=1,f7_5=1,a=5,b=7 -> next cycle out_valid=1, result=32'hFFFF_FFFE, zero=0
//  2 f3=101,f7_5=1,a=32'h8000_0000,b=4 -> 32'hF800_0000; f7_5=0 -> 32'h0800_0000; f3=011,a=-1,b=1 -> 0
//  3 MULH a=-2,b=3 (op_5=f7_0=1,f3=001) -> busy 32 cycles, in_ready=0, result=32'hFFFF_FFFF at N+33; MULHU same -> 2
//  4 out_ready=0 for 5 cycles after 4 back-to-back ADDs -> result held, in_ready=0; release -> all 4 in order, none lost
//  5 flush at cycle 10 of MUL -> busy=0, out_valid never asserts; next ADD 1+1 -> result 2
//  6 rst_n low mid-MUL -> outputs 0 asynchronously; alu_op=11 -> illegal=1, result=0, zero=1

Source files
------------

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: EX-stage ALU with control decode and registered result.
// The M-extension multiply group runs on an iterative shift-add engine.
module alu_seq_exec #(
   parameter int XLEN       = 32,
   parameter int ENABLE_MUL = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic            funct7_0,
   input  logic            op_5,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   typedef enum logic [0:0] {
      S_IDLE,
      S_MUL
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD,
      OP_SUB,
      OP_SLL,
      OP_SLT,
      OP_SLTU,
      OP_XOR,
      OP_SRL,
      OP_SRA,
      OP_OR,
      OP_AND,
      OP_MUL,
      OP_MULH,
      OP_MULHSU,
      OP_MULHU,
      OP_ILL
   } op_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic                neg_q, neg_d;
   logic                hi_q, hi_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                zero_q, zero_d;
   logic                illegal_q, illegal_d;
   logic                out_valid_q, out_valid_d;

   op_t                 dec_op;
   logic                is_mul;
   logic                a_sgn, b_sgn;
   logic                a_neg, b_neg;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic [CW-1:0]       shamt;
   logic [XLEN-1:0]     alu_res;
   logic [2*XLEN-1:0]   pp;
   logic [2*XLEN-1:0]   acc_sum;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     mul_res;
   logic                accept;
   logic                load;
   logic [XLEN-1:0]     new_res;
   logic                new_ill;

   assign busy      = (state_q == S_MUL);
   assign in_ready  = (state_q == S_IDLE) & (~out_valid_q | out_ready) & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

   // Decode ALU control fields into a single operation
   always_comb begin
      dec_op = OP_ILL;
      unique case (alu_op)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = OP_SUB;
         2'b10: begin
            if (op_5 && funct7_0) begin
               if (ENABLE_MUL != 0) begin
                  unique case (funct3)
                     3'b000:  dec_op = OP_MUL;
                     3'b001:  dec_op = OP_MULH;
                     3'b010:  dec_op = OP_MULHSU;
                     3'b011:  dec_op = OP_MULHU;
                     default: dec_op = OP_ILL;
                  endcase
               end
            end else begin
               unique case (funct3)
                  3'b000:  dec_op = (op_5 && funct7_5) ? OP_SUB : OP_ADD;
                  3'b001:  dec_op = OP_SLL;
                  3'b010:  dec_op = OP_SLT;
                  3'b011:  dec_op = OP_SLTU;
                  3'b100:  dec_op = OP_XOR;
                  3'b101:  dec_op = funct7_5 ? OP_SRA : OP_SRL;
                  3'b110:  dec_op = OP_OR;
                  default: dec_op = OP_AND;
               endcase
            end
         end
         default: dec_op = OP_ILL;
      endcase
   end

   // Multiply operand signedness and magnitudes
   always_comb begin
      is_mul = (dec_op == OP_MUL) || (dec_op == OP_MULH) ||
               (dec_op == OP_MULHSU) || (dec_op == OP_MULHU);
      a_sgn  = (dec_op == OP_MULH) || (dec_op == OP_MULHSU);
      b_sgn  = (dec_op == OP_MULH);
      a_neg  = a_sgn & operand_a[XLEN-1];
      b_neg  = b_sgn & operand_b[XLEN-1];
      a_mag  = a_neg ? -operand_a : operand_a;
      b_mag  = b_neg ? -operand_b : operand_b;
   end

   // Single-cycle ALU result
   always_comb begin
      shamt   = operand_b[CW-1:0];
      alu_res = '0;
      unique case (dec_op)
         OP_ADD:  alu_res = operand_a + operand_b;
         OP_SUB:  alu_res = operand_a - operand_b;
         OP_SLL:  alu_res = operand_a << shamt;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                             $signed(operand_a) < $signed(operand_b)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
         OP_XOR:  alu_res = operand_a ^ operand_b;
         OP_SRL:  alu_res = operand_a >> shamt;
         OP_SRA:  alu_res = $signed(operand_a) >>> shamt;
         OP_OR:   alu_res = operand_a | operand_b;
         OP_AND:  alu_res = operand_a & operand_b;
         default: alu_res = '0;
      endcase
   end

   // One shift-add step plus final sign fix-up and half select
   always_comb begin
      pp      = mplier_q[0] ? mcand_q : '0;
      acc_sum = acc_q + pp;
      prod    = neg_q ? -acc_sum : acc_sum;
      mul_res = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
   end

   // Next-state for control FSM, multiply engine and output register
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      neg_d       = neg_q;
      hi_d        = hi_q;
      out_valid_d = out_valid_q & ~out_ready;
      load        = 1'b0;
      new_res     = '0;
      new_ill     = 1'b0;
      if (flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state_d  = S_MUL;
                     cnt_d    = '0;
                     mcand_d  = {{XLEN{1'b0}}, a_mag};
                     mplier_d = b_mag;
                     acc_d    = '0;
                     neg_d    = a_neg ^ b_neg;
                     hi_d     = (dec_op != OP_MUL);
                  end else begin
                     out_valid_d = 1'b1;
                     load        = 1'b1;
                     new_ill     = (dec_op == OP_ILL);
                     new_res     = new_ill ? '0 : alu_res;
                  end
               end
            end
            S_MUL: begin
               acc_d    = acc_sum;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b1;
                  load        = 1'b1;
                  new_res     = mul_res;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      result_d  = load ? new_res : result_q;
      zero_d    = load ? (new_res == '0) : zero_q;
      illegal_d = load ? new_ill : illegal_q;
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         neg_q       <= 1'b0;
         hi_q        <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         neg_q       <= neg_d;
         hi_q        <= hi_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed and random checks of alu_seq_exec
// against an arithmetic reference model and result scoreboard.
module tb_alu_seq_exec;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  alu_op = '0;
   logic [2:0]  funct3 = '0;
   logic        funct7_5 = 1'b0;
   logic        funct7_0 = 1'b0;
   logic        op_5 = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        zero;
   logic        illegal;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] r;
      logic        il;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   alu_seq_exec dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .funct7_0  (funct7_0),
      .op_5      (op_5),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [1:0] aop,
                                  input logic [2:0] f3,
                                  input logic f75, f70, o5,
                                  input logic [31:0] a, b);
      exp_t        e;
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      int          sh;
      sa = $signed(a);
      sb = $signed(b);
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sh = int'(b[4:0]);
      e.r = '0;
      e.il = 1'b0;
      p = '0;
      case (aop)
         2'd0: e.r = a + b;
         2'd1: e.r = a - b;
         2'd3: e.il = 1'b1;
         default: begin
            if (o5 && f70) begin
               case (f3)
                  3'd0: begin p = sa * sb; e.r = p[31:0]; end
                  3'd1: begin p = sa * sb; e.r = p[63:32]; end
                  3'd2: begin p = sa * ub; e.r = p[63:32]; end
                  3'd3: begin p = ua * ub; e.r = p[63:32]; end
                  default: e.il = 1'b1;
               endcase
            end else begin
               case (f3)
                  3'd0: e.r = (o5 && f75) ? a - b : a + b;
                  3'd1: e.r = a << sh;
                  3'd2: e.r = (sa < sb) ? 32'd1 : 32'd0;
                  3'd3: e.r = (a < b) ? 32'd1 : 32'd0;
                  3'd4: e.r = a ^ b;
                  3'd5: e.r = f75 ? 32'(sa >>> sh) : a >> sh;
                  3'd6: e.r = a | b;
                  default: e.r = a & b;
               endcase
            end
         end
      endcase
      return e;
   endfunction

   // Scoreboard: queue expectations on accept, compare on delivery
   always @(negedge clk) begin
      if (rst_n) begin
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("spurious_out", 1, 0);
               end else begin
                  mon_e = q.pop_front();
                  chk("sb_result", result, mon_e.r);
                  chk("sb_illegal", illegal, mon_e.il);
                  chk("sb_zero", zero, mon_e.r == 32'd0);
               end
            end
            if (in_valid && in_ready)
               q.push_back(model(alu_op, funct3, funct7_5, funct7_0,
                                 op_5, operand_a, operand_b));
         end
      end
   end

   always @(negedge rst_n) q.delete();

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [1:0] aop, input logic [2:0] f3,
                        input logic f75, f70, o5,
                        input logic [31:0] a, b);
      bit ok;
      ok = 1'b0;
      alu_op = aop; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
      op_5 = o5; operand_a = a; operand_b = b; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
      if (!ok) chk("accept_timeout", 0, 1);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic single(input string tag, input logic [1:0] aop,
                         input logic [2:0] f3, input logic f75, f70, o5,
                         input logic [31:0] a, b, exp);
      issue(aop, f3, f75, f70, o5, a, b);
      @(negedge clk);
      chk({tag, "_vld"}, out_valid, 1);
      chk(tag, result, exp);
      cyc();
   endtask

   task automatic mul_lat(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, b, exp);
      int k;
      int bn;
      k = 0;
      bn = 0;
      issue(2'b10, f3, 1'b0, 1'b1, 1'b1, a, b);
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            k = i;
            break;
         end
         if (busy && !in_ready) bn++;
         cyc();
      end
      chk({tag, "_lat"}, k, 33);
      chk({tag, "_busy"}, bn, 32);
      chk({tag, "_res"}, result, exp);
      cyc();
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int seen;
      int r;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_busy", busy, 0);
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", in_ready, 1);
      cyc();

      single("sub", 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7,
             32'hFFFF_FFFE);
      single("addi", 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7,
             32'd12);
      single("sra", 2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000,
             32'd4, 32'hF800_0000);
      single("srl", 2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000,
             32'd4, 32'h0800_0000);
      single("sltu", 2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,
             32'd1, 32'd0);
      chk("sltu_zero", zero, 1);
      single("slt", 2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,
             32'd1, 32'd1);
      single("sll0", 2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'h1234_5678,
             32'd32, 32'h1234_5678);

      mul_lat("mulh", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
      mul_lat("mulhu", 3'b011, 32'hFFFF_FFFE, 32'd3, 32'd2);
      mul_lat("mul", 3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
      mul_lat("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFF);

      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alu_op = 2'b00; operand_a = 32'(i * 1000 + 17);
         operand_b = 32'(i + 5); in_valid = 1'b1;
         @(negedge clk);
         chk("b2b_ready", in_ready, 1);
         cyc();
      end
      out_ready = 1'b0;
      operand_a = 32'd40;
      operand_b = 32'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_ready", in_ready, 0);
         chk("hold_valid", out_valid, 1);
         chk("hold_result", result, 32'd3025);
         cyc();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("fifth_result", result, 32'd42);
      cyc();

      issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd7, 32'd9);
      repeat (9) cyc();
      flush = 1'b1;
      @(negedge clk);
      chk("flush_ready", in_ready, 0);
      cyc();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", busy, 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen = 1;
         cyc();
         @(negedge clk);
      end
      chk("flush_no_out", seen, 0);
      cyc();
      single("post_flush", 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1,
             32'd1, 32'd2);

      flush = 1'b1;
      alu_op = 2'b00; operand_a = 32'd3; operand_b = 32'd4;
      in_valid = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      cyc();
      flush = 1'b0;
      @(negedge clk);
      chk("unflush_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("unflush_result", result, 32'd7);
      cyc();

      issue(2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'd3, 32'd5);
      repeat (5) cyc();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_result", result, 0);
      chk("arst_illegal", illegal, 0);
      cyc();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
         cyc();
      end
      chk("arst_no_out", seen, 0);
      single("illegal", 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'd9,
             32'd9, 32'd0);
      chk("illegal_flag", illegal, 1);
      chk("illegal_zero", zero, 1);

      for (int i = 0; i < 600; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 59) == 0) && !(out_valid && out_ready);
         in_valid = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 9);
         alu_op = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 :
                  (r == 9) ? 2'b11 : 2'b10;
         funct3 = 3'($urandom_range(0, 7));
         funct7_5 = 1'($urandom_range(0, 1));
         funct7_0 = ($urandom_range(0, 2) == 0);
         op_5 = 1'($urandom_range(0, 1));
         operand_a = rnd_val();
         operand_b = rnd_val();
         @(negedge clk);
         cyc();
      end

      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !busy && !out_valid) break;
         cyc();
      end
      chk("drain", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
